// File: rtl/seg7_pkg.sv
// Shared code constants and the 4-bit code to 7-segment glyph decoder.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:       seg = 7'b1000000;
      4'h1:       seg = 7'b1111001;
      4'h2:       seg = 7'b0100100;
      4'h3:       seg = 7'b0110000;
      4'h4:       seg = 7'b0011001;
      4'h5:       seg = 7'b0010010;
      4'h6:       seg = 7'b0000010;
      4'h7:       seg = 7'b1111000;
      4'h8:       seg = 7'b0000000;
      4'h9:       seg = 7'b0010000;
      CODE_MINUS: seg = 7'b0111111;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Per-slot refresh counter and digit index for the display scanner.
// Reports the slot wrap, the anode guard window and the current/next index.
module seg7_refresh_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  localparam int CW = $clog2(REFRESH_DIV),
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          slot_wrap,
  output logic          in_guard,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] next_idx
);

  logic [CW-1:0] cnt;

  assign slot_wrap = (cnt == CW'(REFRESH_DIV - 1));
  assign in_guard  = (int'(cnt) < GUARD);
  assign next_idx  = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= next_idx;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver: load-strobed shadow registers,
// leading-zero blanking, per-slot digit latch, anode guard and output polarity.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    lz_blank_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] MASK_RST = ~NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? '1 : '0;

  logic          slot_wrap, in_guard;
  logic [IW-1:0] idx, next_idx;

  seg7_refresh_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_wrap(slot_wrap),
    .in_guard (in_guard),
    .idx      (idx),
    .next_idx (next_idx)
  );

  logic [4*NUM_DIGITS-1:0] code_sh;
  logic [NUM_DIGITS-1:0]   dp_sh, mask_sh, mask_d;
  logic                    zero_above;

  // A digit blanks only when it and every more significant digit are code 0.
  always_comb begin
    mask_d     = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (data_i[4*k +: 4] == 4'h0);
      if (k > 0) mask_d[k] = lz_blank_i & zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_sh <= {NUM_DIGITS{CODE_BLANK}};
      dp_sh   <= '0;
      mask_sh <= MASK_RST;
    end else if (load_i) begin
      code_sh <= data_i;
      dp_sh   <= dp_i;
      mask_sh <= mask_d;
    end
  end

  logic [3:0] nxt_code;
  logic       nxt_dp, nxt_mask;

  always_comb begin
    nxt_code = CODE_BLANK;
    nxt_dp   = 1'b0;
    nxt_mask = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (next_idx == IW'(k)) begin
        nxt_code = code_sh[4*k +: 4];
        nxt_dp   = dp_sh[k];
        nxt_mask = mask_sh[k];
      end
    end
  end

  // Stage p0: slot latch, captured on the wrap so a mid-slot load never
  // disturbs the digit currently lit.
  logic [3:0] slot_code_p0;
  logic       slot_dp_p0, slot_mask_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_code_p0 <= CODE_BLANK;
      slot_dp_p0   <= 1'b0;
      slot_mask_p0 <= 1'b0;
    end else if (slot_wrap) begin
      slot_code_p0 <= nxt_code;
      slot_dp_p0   <= nxt_dp;
      slot_mask_p0 <= nxt_mask;
    end
  end

  logic [6:0]            seg_lit;
  logic                  dp_lit;
  logic [NUM_DIGITS-1:0] an_lit;

  assign seg_lit = slot_mask_p0 ? SEG_BLANK : seg7_decode(slot_code_p0);
  assign dp_lit  = slot_dp_p0 & ~slot_mask_p0;
  assign an_lit  = in_guard ? '0 : (NUM_DIGITS'(1) << idx);

  // Stage p1: registered pins in board polarity (seg_lit is already active-low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_OFF;
      dp_o  <= ACTIVE_LOW;
      an_o  <= AN_OFF;
    end else begin
      seg_o <= ACTIVE_LOW ? seg_lit : ~seg_lit;
      dp_o  <= ACTIVE_LOW ? ~dp_lit : dp_lit;
      an_o  <= ACTIVE_LOW ? ~an_lit : an_lit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: frame expectations are queued by the
// stimulus and popped by a slot monitor; a second 1-digit active-high instance.
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = ND * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load, lz;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;

  logic [3:0]  data1;
  logic [0:0]  dp1;
  logic        load1, lz1;
  logic [6:0]  seg1;
  logic        dpo1;
  logic [0:0]  an1;

  always #5 clk = ~clk;

  seg7_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .GUARD(GRD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data), .dp_i(dp), .load_i(load),
    .lz_blank_i(lz), .seg_o(seg), .dp_o(dpo), .an_o(an)
  );

  seg7_scan_mux #(.NUM_DIGITS(1), .REFRESH_DIV(DIV), .GUARD(GRD), .ACTIVE_LOW(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data1), .dp_i(dp1), .load_i(load1),
    .lz_blank_i(lz1), .seg_o(seg1), .dp_o(dpo1), .an_o(an1)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpx;
  } slot_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [1:0]  j;
    logic [27:0] segs;
    logic [3:0]  dl;
  } vec_t;

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dl);
    slot_t s;
    for (int k = 0; k < ND; k++) begin
      s.an  = ~(4'b0001 << k);
      s.seg = segs[7*k +: 7];
      s.dpx = ~dl[k];
      exp_q.push_back(s);
    end
  endtask

  // Slot monitor: pop on the first lit cycle, then check length and stability.
  slot_t cur, e;
  bit    prev_vis = 1'b0;
  int    vcnt = 0;
  bit    stable = 1'b1;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (an != 4'hF) begin
        if (!prev_vis) begin
          cur    = {an, seg, dpo};
          vcnt   = 1;
          stable = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_slot: an=%b seg=%h with nothing queued", an, seg);
          end else begin
            e = exp_q.pop_front();
            check("slot_an", 16'(an), 16'(e.an));
            check("slot_seg", 16'(seg), 16'(e.seg));
            check("slot_dp", 16'(dpo), 16'(e.dpx));
          end
        end else begin
          vcnt++;
          if ({an, seg, dpo} !== cur) stable = 1'b0;
        end
      end else if (prev_vis) begin
        check("slot_len", 16'(vcnt), 16'(DIV - GRD));
        check("slot_stable", 16'(stable), 16'(1));
      end
      prev_vis = (an != 4'hF);
    end
  end

  vec_t        vecs[7];
  logic [27:0] prev_segs, mix_segs;
  logic [3:0]  prev_dl, mix_dl;

  initial begin
    // segs = {d3,d2,d1,d0}; dl = lit decimal points
    vecs[0] = '{16'h4321, 4'b0000, 1'b0, 2'd0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b0000};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, 2'd0, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0000};
    vecs[2] = '{16'h0070, 4'b0000, 1'b0, 2'd0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0000};
    vecs[3] = '{16'hA005, 4'b0001, 1'b1, 2'd0, {7'h3F, 7'h40, 7'h40, 7'h12}, 4'b0001};
    vecs[4] = '{16'h0000, 4'b1000, 1'b1, 2'd0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000};
    vecs[5] = '{16'h4321, 4'b0000, 1'b0, 2'd0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b0000};
    vecs[6] = '{16'h9999, 4'b0000, 1'b0, 2'd1, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b0000};

    data = '0; dp = '0; load = 1'b0; lz = 1'b0;
    data1 = '0; dp1 = '0; load1 = 1'b0; lz1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dpo), 16'h1);
    check("rst_an_pol", 16'(an1), 16'h0);
    check("rst_seg_pol", 16'(seg1), 16'h00);

    prev_segs = {4{7'h7F}};
    prev_dl   = 4'b0000;
    rst_n     = 1'b1;
    push_frame(prev_segs, prev_dl);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wait_cyc(FRAME * (2 * i + 1));
      for (int k = 0; k < ND; k++) begin
        if (k > int'(vecs[i].j)) begin
          mix_segs[7*k +: 7] = vecs[i].segs[7*k +: 7];
          mix_dl[k]          = vecs[i].dl[k];
        end else begin
          mix_segs[7*k +: 7] = prev_segs[7*k +: 7];
          mix_dl[k]          = prev_dl[k];
        end
      end
      push_frame(mix_segs, mix_dl);
      wait_cyc(FRAME * (2 * i + 1) + DIV * int'(vecs[i].j) + 1);
      data = vecs[i].data;
      dp   = vecs[i].dp;
      lz   = vecs[i].lz;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_cyc(FRAME * (2 * i + 2));
      push_frame(vecs[i].segs, vecs[i].dl);
      prev_segs = vecs[i].segs;
      prev_dl   = vecs[i].dl;
    end

    wait_cyc(FRAME * 15 + 2);
    mon_en = 1'b0;
    check("queue_drained", 16'(exp_q.size()), 16'(0));

    wait_cyc(FRAME * 15 + 5);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_seg", 16'(seg), 16'h7F);
    check("midrst_dp", 16'(dpo), 16'h1);
    check("midrst_an_pol", 16'(an1), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Single-digit, active-high instance: no scan movement, inverted pins.
  initial begin
    wait (rst_n === 1'b1);
    wait_cyc(4);
    check("pol_an_blank", 16'(an1), 16'h1);
    check("pol_seg_blank", 16'(seg1), 16'h00);
    data1 = 4'h8;
    load1 = 1'b1;
    @(posedge clk);
    #1;
    load1 = 1'b0;
    wait_cyc(12);
    check("pol_an_on", 16'(an1), 16'h1);
    check("pol_seg_8", 16'(seg1), 16'h7F);
    check("pol_dp_off", 16'(dpo1), 16'h0);
    wait_cyc(17);
    check("pol_guard0", 16'(an1), 16'h0);
    wait_cyc(18);
    check("pol_guard1", 16'(an1), 16'h0);
    check("pol_seg_guard", 16'(seg1), 16'h7F);
    wait_cyc(19);
    check("pol_an_back", 16'(an1), 16'h1);
  end

endmodule
